fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and operand-address stage for the 6502 core. It sits directly upstream of the decoder. It reads the opcode at PC and reads the operand bytes the addressing mode requires. It resolves indexed and indirect addressing to a single effective address, then presents opcode and address to the decoder on an `instruction_ready` / `instruction_done` handshake. It owns the program counter and advances it by the instruction length, or loads a redirect target.

## Interface
- `REG_WIDTH`, 8, data/register width
- `ADDR_WIDTH`, 16, address width
- `RESET_PC`, 16'h0000, PC value after reset (no vector fetch)

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_addr`  out  ADDR_WIDTH  read address to memory
- `mem_re`  out  1  read strobe
- `mem_rdata`  in  REG_WIDTH  read data, valid the cycle after `mem_addr`/`mem_re`
- `x_in`, `y_in`  in  REG_WIDTH  current X/Y register values
- `instruction_out`  out  REG_WIDTH  opcode (decoder `instruction_in`)
- `addr_out`  out  ADDR_WIDTH  effective/operand address (decoder `addr_in`)
- `instruction_ready`  out  1  opcode + addr_out valid
- `instruction_done`  in  1  decoder finished current instruction
- `pc_load`  in  1  redirect request, sampled with `instruction_done`
- `pc_load_value`  in  ADDR_WIDTH  redirect target
- `pc_out`  out  ADDR_WIDTH  PC of the instruction currently held

## Operation
- Mode classification is combinational on the opcode `aaabbbcc`.
  - cc=01: bbb 000 (zp,X), 001 zp, 010 imm, 011 abs, 100 (zp),Y, 101 zp,X, 110 abs,Y, 111 abs,X.
  - cc=00/10, bbb 000: imm if opcode[7]=1, else implied. Exception: 0x20 is abs.
  - cc=00/10, bbb 001 zp; 010 implied/acc; 011 abs (0x6C treated as abs).
  - cc=00/10, bbb 100: relative if cc=00, else implied.
  - cc=00/10, bbb 101 zp,X; 110 implied; 111 abs,X.
  - Opcodes 0x96/0xB6 use zp,Y; 0xBE uses abs,Y.
  - cc=11 is implied, length 1; the decoder flags it illegal.
- Length: implied = 1; imm/zp/zp-indexed/relative/indirect = 2; abs/abs-indexed = 3.
- Effective address:
  - imm = PC+1.
  - zp = {8'h00, lo}.
  - zp,X/Y = {8'h00, (lo+idx) mod 256}.
  - abs = {hi, lo}.
  - abs,X/Y = ({hi, lo}+idx) mod 2^16.
  - relative = PC+2+sext(lo), mod 2^16.
  - (zp,X): ptr = (lo+X) mod 256; addr = {mem[(ptr+1) mod 256], mem[ptr]}.
  - (zp),Y: addr = ({mem[(lo+1) mod 256], mem[lo]}+Y) mod 2^16.
  - implied = 0.
- X/Y are sampled in the cycle the index is added.
- FSM states: FETCH, OPC, LO, HI, PTR_LO, PTR_HI, READY.
  - FETCH: drive `mem_addr`=PC, `mem_re`=1 → OPC.
  - OPC: latch opcode. Implied → READY. Otherwise drive PC+1 → LO.
  - LO: latch lo. Length 3 → drive PC+2, go to HI. Indirect → drive ptr, go to PTR_LO. Otherwise → READY.
  - HI: latch hi → READY.
  - PTR_LO: latch pointer low byte, drive (ptr+1) mod 256 → PTR_HI.
  - PTR_HI: latch pointer high byte → READY.
  - READY: `instruction_ready`=1 and outputs held stable until `instruction_done`=1. Then PC ← `pc_load` ? `pc_load_value` : PC+length (mod 2^16) → FETCH.
- `instruction_done` outside READY is ignored; `pc_load` without `instruction_done` is ignored.
- `mem_re`=0 in every state that does not drive an address.

## Timing
- Reset values: PC=`RESET_PC`, state FETCH on the first cycle after reset deasserts.
  - `instruction_ready`=0, `instruction_out`=0, `addr_out`=0.
  - `mem_addr`=0, `mem_re`=0, `pc_out`=`RESET_PC`.
- Reset mid-instruction or in READY aborts immediately; no PC update.
- Latency from entering FETCH to `instruction_ready`=1:
  - implied: 2 cycles.
  - 2-byte direct: 3 cycles.
  - abs: 4 cycles.
  - indirect: 5 cycles.
- `instruction_ready` drops the cycle after `instruction_done` is sampled. The next FETCH drives the new PC in that same cycle.
- `instruction_done` held high across READY exit has no effect until the next READY.

## Structure
- Package `fetch_pkg`:
  - addressing-mode constants (IMPL, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, X_IND, IND_Y, REL);
  - FSM state constants;
  - length constants.
- Sub-module `addr_mode_classify`: combinational opcode → {mode, length, index_is_y}; reusable by the decoder.
- The FSM, byte registers, EA adder and PC live in `fetch_unit`.

## Test plan
- 0xEA at 0x0000, `instruction_done` pulsed on the first READY cycle → `instruction_ready` 2 cycles after FETCH, `addr_out`=0, next FETCH `mem_addr`=0x0001.
- A9 42 at 0x0010 (LDA imm) → `addr_out`=0x0011; PC after done = 0x0012.
- BD FF 12 with X=0x01 (LDA abs,X) → `addr_out`=0x1300, latency 4. B5 F0 with X=0x20 (LDA zp,X) → `addr_out`=0x0010, verifying zero-page wrap.
- 81 FF with X=0x00, mem[0xFF]=0x34, mem[0x00]=0x12 (STA (zp,X)) → pointer wraps, `addr_out`=0x1234. B1 10 with mem[0x10]=0xFF, mem[0x11]=0x20, Y=0x01 → `addr_out`=0x2100.
- D0 FE at 0x0200 (BNE) → `addr_out`=0x0200. Done with `pc_load`=1, `pc_load_value`=0x0200 → next `mem_addr`=0x0200.
- `reset` asserted in PTR_LO → next cycle all outputs at reset values; after release, FETCH at `RESET_PC`. `instruction_done` pulsed in OPC → ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage and the decoder.
//   addr_mode_e   : 6502 addressing modes resolved by the fetch stage
//   fetch_state_e : fetch sequencer states
//   instr_len_t   : instruction length in bytes (1..3)
package fetch_pkg;

  typedef enum logic [3:0] {
    IMPL,
    IMM,
    ZPG,
    ZPG_X,
    ZPG_Y,
    ABS,
    ABS_X,
    ABS_Y,
    X_IND,
    IND_Y,
    REL
  } addr_mode_e;

  typedef enum logic [2:0] {
    FETCH,
    OPC,
    LO,
    HI,
    PTR_LO,
    PTR_HI,
    READY
  } fetch_state_e;

  typedef logic [1:0] instr_len_t;

  localparam instr_len_t LEN_1 = 2'd1;
  localparam instr_len_t LEN_2 = 2'd2;
  localparam instr_len_t LEN_3 = 2'd3;

endpackage

// File: rtl/addr_mode_classify.sv
// Combinational 6502 opcode classifier, shared with the decoder.
//   opcode     in  : opcode byte aaabbbcc
//   mode       out : addressing mode
//   length     out : instruction length in bytes
//   index_is_y out : the indexed/indirect-indexed add uses Y rather than X
module addr_mode_classify
  import fetch_pkg::*;
(
  input  logic [7:0]  opcode,
  output addr_mode_e  mode,
  output instr_len_t  length,
  output logic        index_is_y
);

  always_comb begin
    mode = IMPL;
    if (opcode[1:0] == 2'b01) begin
      case (opcode[4:2])
        3'b000:  mode = X_IND;
        3'b001:  mode = ZPG;
        3'b010:  mode = IMM;
        3'b011:  mode = ABS;
        3'b100:  mode = IND_Y;
        3'b101:  mode = ZPG_X;
        3'b110:  mode = ABS_Y;
        default: mode = ABS_X;
      endcase
    end else if (opcode[1:0] == 2'b11) begin
      // Undocumented opcodes: single-byte, the decoder flags them illegal.
      mode = IMPL;
    end else begin
      case (opcode[4:2])
        3'b000:  mode = opcode[7] ? IMM : IMPL;
        3'b001:  mode = ZPG;
        3'b010:  mode = IMPL;
        3'b011:  mode = ABS;  // JMP (ind) 0x6C is fetched as plain abs
        3'b100:  mode = (opcode[1:0] == 2'b00) ? REL : IMPL;
        3'b101:  mode = ZPG_X;
        3'b110:  mode = IMPL;
        default: mode = ABS_X;
      endcase
    end

    // Irregular encodings: JSR, STX/LDX zp,Y and LDX abs,Y.
    if (opcode == 8'h20) mode = ABS;
    if (opcode == 8'h96 || opcode == 8'hB6) mode = ZPG_Y;
    if (opcode == 8'hBE) mode = ABS_Y;
  end

  always_comb begin
    case (mode)
      IMPL:               length = LEN_1;
      ABS, ABS_X, ABS_Y:  length = LEN_3;
      default:            length = LEN_2;
    endcase
  end

  assign index_is_y = (mode == ZPG_Y) || (mode == ABS_Y) || (mode == IND_Y);

endmodule

// File: rtl/fetch_unit.sv
// 6502 instruction fetch and operand-address stage.
// Reads opcode and operand bytes, resolves the effective address and hands
// opcode + address to the decoder on an instruction_ready/instruction_done
// handshake. Owns the PC.
//   clk, reset               : clock, synchronous active-high reset
//   mem_addr/mem_re/mem_rdata: memory read port, data returns one cycle later
//   x_in, y_in               : index register values
//   instruction_out/addr_out : opcode and effective address to the decoder
//   instruction_ready/_done  : decoder handshake
//   pc_load/pc_load_value    : redirect, taken with instruction_done
//   pc_out                   : PC of the held instruction
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [REG_WIDTH-1:0]  instruction_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam int unsigned PadW = ADDR_WIDTH - REG_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  opcode_q, opcode_d;
  logic [REG_WIDTH-1:0]  lo_q, lo_d;
  logic [REG_WIDTH-1:0]  ptr_q, ptr_d;
  logic [REG_WIDTH-1:0]  ptr_lo_q, ptr_lo_d;

  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic                  mem_re_c;

  logic [REG_WIDTH-1:0]  op_cur;
  logic [REG_WIDTH-1:0]  idx;
  logic [REG_WIDTH-1:0]  zp_sum;
  logic [ADDR_WIDTH-1:0] idx_ext;
  logic [ADDR_WIDTH-1:0] short_ea;
  logic [ADDR_WIDTH-1:0] abs_base;
  logic [ADDR_WIDTH-1:0] ptr_base;

  addr_mode_e mode;
  instr_len_t length;
  logic       index_is_y;

  // In OPC the opcode is still on mem_rdata; classify it there so the
  // operand read can be issued without a bubble.
  assign op_cur = (state_q == OPC) ? mem_rdata : opcode_q;

  addr_mode_classify u_classify (
    .opcode     (op_cur),
    .mode       (mode),
    .length     (length),
    .index_is_y (index_is_y)
  );

  assign idx      = index_is_y ? y_in : x_in;
  assign idx_ext  = {{PadW{1'b0}}, idx};
  assign zp_sum   = mem_rdata + idx;  // wraps inside page zero
  assign abs_base = {mem_rdata, lo_q};
  assign ptr_base = {mem_rdata, ptr_lo_q};

  // Two-byte effective addresses, formed from the operand byte in LO.
  always_comb begin
    case (mode)
      IMM:          short_ea = pc_q + ADDR_WIDTH'(1);
      ZPG:          short_ea = {{PadW{1'b0}}, mem_rdata};
      ZPG_X, ZPG_Y: short_ea = {{PadW{1'b0}}, zp_sum};
      REL:          short_ea = pc_q + ADDR_WIDTH'(2) +
                               {{PadW{mem_rdata[REG_WIDTH-1]}}, mem_rdata};
      default:      short_ea = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    opcode_d   = opcode_q;
    lo_d       = lo_q;
    ptr_d      = ptr_q;
    ptr_lo_d   = ptr_lo_q;
    mem_addr_c = '0;
    mem_re_c   = 1'b0;

    case (state_q)
      FETCH: begin
        mem_addr_c = pc_q;
        mem_re_c   = 1'b1;
        state_d    = OPC;
      end
      OPC: begin
        opcode_d = mem_rdata;
        if (mode == IMPL) begin
          addr_d  = '0;
          state_d = READY;
        end else begin
          mem_addr_c = pc_q + ADDR_WIDTH'(1);
          mem_re_c   = 1'b1;
          state_d    = LO;
        end
      end
      LO: begin
        lo_d = mem_rdata;
        if (length == LEN_3) begin
          mem_addr_c = pc_q + ADDR_WIDTH'(2);
          mem_re_c   = 1'b1;
          state_d    = HI;
        end else if (mode == X_IND || mode == IND_Y) begin
          // (zp,X) indexes the pointer; (zp),Y indexes the loaded address.
          ptr_d      = (mode == X_IND) ? zp_sum : mem_rdata;
          mem_addr_c = {{PadW{1'b0}}, ptr_d};
          mem_re_c   = 1'b1;
          state_d    = PTR_LO;
        end else begin
          addr_d  = short_ea;
          state_d = READY;
        end
      end
      HI: begin
        addr_d  = (mode == ABS) ? abs_base : abs_base + idx_ext;
        state_d = READY;
      end
      PTR_LO: begin
        ptr_lo_d   = mem_rdata;
        mem_addr_c = {{PadW{1'b0}}, ptr_q + REG_WIDTH'(1)};
        mem_re_c   = 1'b1;
        state_d    = PTR_HI;
      end
      PTR_HI: begin
        addr_d  = (mode == IND_Y) ? ptr_base + idx_ext : ptr_base;
        state_d = READY;
      end
      READY: begin
        if (instruction_done) begin
          pc_d    = pc_load ? pc_load_value : pc_q + ADDR_WIDTH'(length);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      opcode_q <= '0;
      lo_q     <= '0;
      ptr_q    <= '0;
      ptr_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      opcode_q <= opcode_d;
      lo_q     <= lo_d;
      ptr_q    <= ptr_d;
      ptr_lo_q <= ptr_lo_d;
    end
  end

  // While reset is held the state register already reads FETCH; keep the
  // memory port quiet until reset is released.
  assign mem_re            = mem_re_c & ~reset;
  assign mem_addr          = reset ? '0 : mem_addr_c;
  assign instruction_out   = opcode_q;
  assign addr_out          = addr_q;
  assign instruction_ready = (state_q == READY);
  assign pc_out            = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int M_IMPL = 0, M_IMM = 1, M_ZPG = 2, M_ZPGX = 3, M_ZPGY = 4, M_ABS = 5;
  localparam int M_ABSX = 6, M_ABSY = 7, M_XIND = 8, M_INDY = 9, M_REL = 10;
  localparam int TAB01 [8] = '{M_XIND, M_ZPG, M_IMM, M_ABS, M_INDY, M_ZPGX, M_ABSY, M_ABSX};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [7:0]  x_in, y_in;
  logic [7:0]  instruction_out;
  logic [15:0] addr_out;
  logic        instruction_ready;
  logic        instruction_done;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] pc_out;

  logic [7:0]  mem [0:65535];
  logic [15:0] cur_pc;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  fetch_unit #(
    .REG_WIDTH  (8),
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr          (mem_addr),
    .mem_re            (mem_re),
    .mem_rdata         (mem_rdata),
    .x_in              (x_in),
    .y_in              (y_in),
    .instruction_out   (instruction_out),
    .addr_out          (addr_out),
    .instruction_ready (instruction_ready),
    .instruction_done  (instruction_done),
    .pc_load           (pc_load),
    .pc_load_value     (pc_load_value),
    .pc_out            (pc_out)
  );

  // Reference model: addressing mode from the opcode rules.
  function automatic int ref_mode(input logic [7:0] op);
    int cc, bbb;
    if (op == 8'h20) return M_ABS;
    if (op == 8'h96 || op == 8'hB6) return M_ZPGY;
    if (op == 8'hBE) return M_ABSY;
    cc  = int'(op) % 4;
    bbb = (int'(op) / 4) % 8;
    if (cc == 3) return M_IMPL;
    if (cc == 1) return TAB01[bbb];
    if (bbb == 0) return (op >= 8'h80) ? M_IMM : M_IMPL;
    if (bbb == 1) return M_ZPG;
    if (bbb == 3) return M_ABS;
    if (bbb == 4) return (cc == 0) ? M_REL : M_IMPL;
    if (bbb == 5) return M_ZPGX;
    if (bbb == 7) return M_ABSX;
    return M_IMPL;
  endfunction

  function automatic int ref_len(input int m);
    if (m == M_IMPL) return 1;
    if (m == M_ABS || m == M_ABSX || m == M_ABSY) return 3;
    return 2;
  endfunction

  function automatic int ref_lat(input int m);
    if (m == M_IMPL) return 2;
    if (m == M_XIND || m == M_INDY) return 5;
    return ref_len(m) + 1;
  endfunction

  function automatic int ref_ea(input logic [15:0] pc, input int m, input int x, input int y);
    int p, lo, hi, s, ptr;
    p  = int'(pc);
    lo = int'(mem[(p + 1) % 65536]);
    hi = int'(mem[(p + 2) % 65536]);
    case (m)
      M_IMM:  return (p + 1) % 65536;
      M_ZPG:  return lo;
      M_ZPGX: return (lo + x) % 256;
      M_ZPGY: return (lo + y) % 256;
      M_ABS:  return hi * 256 + lo;
      M_ABSX: return (hi * 256 + lo + x) % 65536;
      M_ABSY: return (hi * 256 + lo + y) % 65536;
      M_REL: begin
        s = (lo >= 128) ? lo - 256 : lo;
        return (p + 2 + s + 65536) % 65536;
      end
      M_XIND: begin
        ptr = (lo + x) % 256;
        return int'(mem[(ptr + 1) % 256]) * 256 + int'(mem[ptr]);
      end
      M_INDY: return (int'(mem[(lo + 1) % 256]) * 256 + int'(mem[lo]) + y) % 65536;
      default: return 0;
    endcase
  endfunction

  // Runs one instruction starting in FETCH at cur_pc. junk pulses done/pc_load
  // during OPC; hold leaves done high across the READY exit.
  task automatic exec(input logic [7:0] x, input logic [7:0] y, input bit ld,
                      input logic [15:0] tgt, input bit junk, input bit hold);
    int m, lat, ea, cnt, k;
    logic [7:0]  op;
    logic [15:0] nxt;
    op  = mem[cur_pc];
    m   = ref_mode(op);
    lat = ref_lat(m);
    ea  = ref_ea(cur_pc, m, int'(x), int'(y));
    nxt = ld ? tgt : cur_pc + 16'(ref_len(m));
    x_in = x;
    y_in = y;
    total++;
    if (mem_re !== 1'b1 || mem_addr !== cur_pc)
      $display("FAIL fetch_addr: got re=%b addr=%h want re=1 addr=%h", mem_re, mem_addr, cur_pc);
    else passed++;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      instruction_done = (cnt == 1) ? junk : 1'b0;
      pc_load          = (cnt == 1) ? junk : 1'b0;
      pc_load_value    = 16'hDEAD;
    end while (!instruction_ready && cnt < 12);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    total++;
    if (cnt !== lat) $display("FAIL latency op=%h: got %0d want %0d", op, cnt, lat);
    else passed++;
    total++;
    if (instruction_out !== op) $display("FAIL opcode: got %h want %h", instruction_out, op);
    else passed++;
    total++;
    if (addr_out !== 16'(ea)) $display("FAIL addr_out op=%h pc=%h: got %h want %h",
                                       op, cur_pc, addr_out, 16'(ea));
    else passed++;
    total++;
    if (pc_out !== cur_pc) $display("FAIL pc_out: got %h want %h", pc_out, cur_pc);
    else passed++;
    k = $urandom_range(0, 2);
    repeat (k) @(negedge clk);
    total++;
    if (instruction_ready !== 1'b1 || addr_out !== 16'(ea) || instruction_out !== op)
      $display("FAIL ready_hold: got rdy=%b addr=%h op=%h want rdy=1 addr=%h op=%h",
               instruction_ready, addr_out, instruction_out, 16'(ea), op);
    else passed++;
    instruction_done = 1'b1;
    pc_load = ld;
    pc_load_value = tgt;
    @(negedge clk);
    if (hold) begin
      pc_load = 1'b1;
      pc_load_value = 16'hBEEF;
    end else begin
      instruction_done = 1'b0;
      pc_load = 1'b0;
    end
    total++;
    if (instruction_ready !== 1'b0 || mem_re !== 1'b1 || mem_addr !== nxt || pc_out !== nxt)
      $display("FAIL next_fetch: got rdy=%b re=%b addr=%h pc=%h want rdy=0 re=1 addr=pc=%h",
               instruction_ready, mem_re, mem_addr, pc_out, nxt);
    else passed++;
    cur_pc = nxt;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (instruction_ready !== 1'b0 || instruction_out !== 8'h00 || addr_out !== 16'h0000)
      $display("FAIL %s_dec: got rdy=%b op=%h addr=%h want 0/00/0000", tag,
               instruction_ready, instruction_out, addr_out);
    else passed++;
    total++;
    if (mem_re !== 1'b0 || mem_addr !== 16'h0000)
      $display("FAIL %s_mem: got re=%b addr=%h want 0/0000", tag, mem_re, mem_addr);
    else passed++;
    total++;
    if (pc_out !== 16'h0000) $display("FAIL %s_pc: got %h want 0000", tag, pc_out);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction_done = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0000;
    x_in = 8'h00;
    y_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    #1;
    cur_pc = 16'h0000;
  endtask

  task automatic test_directed();
    mem[16'h0000] = 8'hEA; mem[16'h0001] = 8'hEA;
    mem[16'h0010] = 8'hA9; mem[16'h0011] = 8'h42;
    mem[16'h0012] = 8'hBD; mem[16'h0013] = 8'hFF; mem[16'h0014] = 8'h12;
    mem[16'h0015] = 8'hB5; mem[16'h0016] = 8'hF0;
    mem[16'h0017] = 8'h81; mem[16'h0018] = 8'hFF; mem[16'h00FF] = 8'h34;
    mem[16'h0019] = 8'hB1; mem[16'h001A] = 8'h10;
    mem[16'h001B] = 8'hEA;
    mem[16'h0200] = 8'hD0; mem[16'h0201] = 8'hFE;
    exec(8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);  // NOP -> 0001
    exec(8'h00, 8'h00, 1'b1, 16'h0010, 1'b1, 1'b0);  // NOP, done in OPC ignored
    mem[16'h0000] = 8'h12;                           // pointer high byte at 00
    exec(8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);  // LDA #42, done held
    mem[16'h0010] = 8'hFF; mem[16'h0011] = 8'h20;    // (zp),Y pointer
    exec(8'h01, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);  // LDA abs,X -> 1300
    exec(8'h20, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);  // LDA zp,X -> 0010
    exec(8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);  // STA (zp,X) -> 1234
    exec(8'h00, 8'h01, 1'b0, 16'h0000, 1'b0, 1'b0);  // LDA (zp),Y -> 2100
    exec(8'h00, 8'h00, 1'b1, 16'h0200, 1'b0, 1'b0);  // NOP, jump to 0200
    exec(8'h00, 8'h00, 1'b1, 16'h0200, 1'b0, 1'b0);  // BNE * -> 0200
  endtask

  task automatic test_reset_mid();
    mem[16'h0200] = 8'hA1;
    mem[16'h0201] = 8'h05;
    x_in = 8'h03;
    instruction_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 16'h0009)
      $display("FAIL ptr_lo_addr: got re=%b addr=%h want re=1 addr=0009", mem_re, mem_addr);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid");
    reset = 1'b0;
    #1;
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 16'h0000)
      $display("FAIL restart_fetch: got re=%b addr=%h want re=1 addr=0000", mem_re, mem_addr);
    else passed++;
    cur_pc = 16'h0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      mem[cur_pc]          = 8'($urandom_range(0, 255));
      mem[cur_pc + 16'd1]  = 8'($urandom_range(0, 255));
      mem[cur_pc + 16'd2]  = 8'($urandom_range(0, 255));
      exec(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 65535)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
